uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame.
REQ-002 CLK  input  1  transmit bit clock; one serial bit per rising edge.
REQ-003 RST  input  1  reset, synchronous, active-low.
REQ-004 P_DATA  input  DATA_WIDTH  parallel byte to transmit.
REQ-005 Data_Valid  input  1  P_DATA, PAR_EN and PAR_TYP valid this cycle.
REQ-006 PAR_EN  input  1  1 = insert parity bit.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 TX_OUT  output  1  serial line, registered, idles high.
REQ-009 Busy  output  1  registered, high while a frame is in flight.

Function
REQ-010 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-011 Acceptance SHALL occur on an edge where Data_Valid=1 and state is IDLE, or state is STOP on its final cycle; P_DATA, PAR_EN and PAR_TYP SHALL be latched into internal registers on that edge.
REQ-012 Data_Valid in START, DATA or PARITY SHALL be ignored, with no buffering.
REQ-013 After acceptance at edge N, TX_OUT SHALL be 0 (start bit) and Busy 1 for the cycle following edge N.
REQ-014 DATA SHALL last DATA_WIDTH cycles, driving latched data LSB first; a bit counter 0..DATA_WIDTH-1 SHALL be cleared on entering DATA.
REQ-015 PARITY SHALL be entered only when latched PAR_EN=1 and last one cycle; parity bit = XOR of latched data when PAR_TYP=0, inverted XOR when PAR_TYP=1.
REQ-016 With latched PAR_EN=0, DATA SHALL go straight to STOP.
REQ-017 STOP SHALL drive TX_OUT=1 for one cycle.
REQ-018 Frame length SHALL be DATA_WIDTH+3 cycles with parity and DATA_WIDTH+2 without (11 and 10 at default).
REQ-019 Leaving STOP with no acceptance, state SHALL return to IDLE with TX_OUT=1 and Busy=0 on the next cycle.
REQ-020 Leaving STOP with acceptance, state SHALL go to START with no idle bit between frames, and Busy SHALL stay 1.
REQ-021 Input changes during a frame SHALL NOT alter the frame in flight.
REQ-022 TX_OUT and Busy SHALL come directly from flops, with no combinational path from inputs.

Reset
REQ-023 On an edge with RST=0: state IDLE, TX_OUT=1, Busy=0, bit counter 0, latched data 0. This applies in any state, including mid-frame.
REQ-024 Data_Valid on an edge with RST=0 SHALL be discarded.
REQ-025 The first acceptance SHALL be possible on the first edge with RST=1.

Verification
REQ-026 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1; Busy high exactly 11 cycles.
REQ-027 P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> data bits 1,0,0,0,0,0,0,0, then parity 0, then stop 1.
REQ-028 P_DATA=0xFF, PAR_EN=0 -> 0, eight 1s, then stop 1; Busy high exactly 10 cycles; TX_OUT returns to idle 1.
REQ-029 Data_Valid held high with 0x3C then 0xC3 (switched in the stop cycle), PAR_EN=0 -> two contiguous 10-bit frames with no idle bit; Busy never drops between them.
REQ-030 Data_Valid with 0x55 pulsed in the 4th DATA cycle of a 0x00 frame -> pulse ignored; 0x00 frame sent intact; line then idles.
REQ-031 RST=0 on the 5th cycle of a frame -> TX_OUT=1 and Busy=0 after that edge; a new 0x81 frame, PAR_EN=1, PAR_TYP=0 -> 0,1,0,0,0,0,0,0,1,0,1.

Source files
------------

// File: rtl/uart_tx.sv
// Serial transmitter: start bit, DATA_WIDTH data bits LSB first, optional even/odd
// parity bit, one stop bit. TX_OUT and Busy are driven straight from flops.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic [2:0]            dbg_state
);
    // Handshake: Data_Valid is a request with no ready. It is taken only when the
    // FSM is in IDLE or in its STOP cycle; at any other time it is dropped, so the
    // sender must watch Busy. Payload and parity controls are captured on that edge.

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, next_state;
    logic [CW-1:0]         bit_cnt, next_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q, par_typ_q;
    logic                  accept, next_tx, next_busy;

    assign dbg_state = state;

    always_comb begin
        next_state = state;
        next_cnt   = bit_cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (Data_Valid) begin
                    accept     = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                next_state = DATA;
                next_cnt   = '0;
            end
            DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    next_state = par_en_q ? PARITY : STOP;
                end else begin
                    next_cnt = bit_cnt + 1'b1;
                end
            end
            PARITY: next_state = STOP;
            STOP: begin
                if (Data_Valid) begin
                    accept     = 1'b1;
                    next_state = START;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Line value for the upcoming cycle, so the flopped output lines up with state.
    always_comb begin
        next_tx   = 1'b1;
        next_busy = (next_state != IDLE);
        case (next_state)
            START:   next_tx = 1'b0;
            DATA:    next_tx = data_q[next_cnt];
            PARITY:  next_tx = (^data_q) ^ par_typ_q;
            default: next_tx = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
        end else begin
            state   <= next_state;
            bit_cnt <= next_cnt;
            TX_OUT  <= next_tx;
            Busy    <= next_busy;
            if (accept) begin
                data_q    <= P_DATA;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames with hand-computed line sequences,
// plus back-to-back, ignored-request and mid-frame reset sequences.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       Busy;
    logic [2:0] dbg_state;

    int checks = 0;
    int failures = 0;

    // exp[i] is the line value in the i-th cycle after acceptance
    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic [10:0] exp;
        int          len;
    } vec_t;

    vec_t vecs[8];

    uart_tx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .dbg_state  (dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " idle tx"}, TX_OUT, 1'b1);
        chk({tag, " idle busy"}, Busy, 1'b0);
    endtask

    // Called at the negedge just after the accepting edge; ends at the stop-bit negedge.
    task automatic check_bits(input logic [10:0] exp, input int len, input string tag);
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge CLK);
            chk($sformatf("%s tx bit%0d", tag, i), TX_OUT, exp[i]);
            chk($sformatf("%s busy bit%0d", tag, i), Busy, 1'b1);
        end
    endtask

    task automatic send_frame(input vec_t v, input string tag);
        P_DATA     = v.data;
        PAR_EN     = v.par_en;
        PAR_TYP    = v.par_typ;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        P_DATA     = ~v.data;
        PAR_EN     = ~v.par_en;
        PAR_TYP    = ~v.par_typ;
        check_bits(v.exp, v.len, tag);
        @(negedge CLK);
        check_idle(tag);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, par_en: 1'b1, par_typ: 1'b0, exp: 11'b10101001010, len: 11};
        vecs[1] = '{data: 8'h01, par_en: 1'b1, par_typ: 1'b1, exp: 11'b10000000010, len: 11};
        vecs[2] = '{data: 8'hFF, par_en: 1'b0, par_typ: 1'b0, exp: 11'b01111111110, len: 10};
        vecs[3] = '{data: 8'h00, par_en: 1'b1, par_typ: 1'b1, exp: 11'b11000000000, len: 11};
        vecs[4] = '{data: 8'hC3, par_en: 1'b1, par_typ: 1'b0, exp: 11'b10110000110, len: 11};
        vecs[5] = '{data: 8'h3C, par_en: 1'b0, par_typ: 1'b0, exp: 11'b01001111000, len: 10};
        vecs[6] = '{data: 8'hC3, par_en: 1'b0, par_typ: 1'b1, exp: 11'b01110000110, len: 10};
        vecs[7] = '{data: 8'h81, par_en: 1'b1, par_typ: 1'b0, exp: 11'b10100000010, len: 11};

        // Reset held with a pending request: nothing may start
        RST        = 1'b0;
        Data_Valid = 1'b1;
        P_DATA     = 8'h5A;
        repeat (3) begin
            @(negedge CLK);
            check_idle("reset");
        end
        chk("reset state idle", dbg_state == 3'd0, 1'b1);

        // First edge out of reset accepts
        RST = 1'b1;
        send_frame(vecs[0], "a5_even");

        for (int k = 1; k < 5; k++)
            send_frame(vecs[k], $sformatf("table%0d", k));

        // Back-to-back frames, request held high, data switched during stop
        P_DATA     = vecs[5].data;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        @(negedge CLK);
        check_bits(vecs[5].exp, vecs[5].len, "b2b_3c");
        P_DATA = vecs[6].data;
        @(negedge CLK);
        Data_Valid = 1'b0;
        check_bits(vecs[6].exp, vecs[6].len, "b2b_c3");
        @(negedge CLK);
        check_idle("b2b");

        // Request pulsed in the 4th data cycle is ignored
        P_DATA     = 8'h00;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge CLK);
            chk($sformatf("ign tx bit%0d", i), TX_OUT, (i == 10));
            chk($sformatf("ign busy bit%0d", i), Busy, 1'b1);
            if (i == 4) begin
                P_DATA     = 8'h55;
                Data_Valid = 1'b1;
            end
            if (i == 5) Data_Valid = 1'b0;
        end
        repeat (3) begin
            @(negedge CLK);
            check_idle("ign after");
        end

        // Reset on the 5th cycle of a frame aborts it
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        check_bits(vecs[0].exp, 5, "abort");
        RST = 1'b0;
        @(negedge CLK);
        check_idle("abort reset");
        RST = 1'b1;
        send_frame(vecs[7], "after_abort_81");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
